// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: synchroniser, integrating debounce,
// press/release pulses, long-press detection and optional auto-repeat.
module btn_debounce_multi #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_PRDS   = 1000,
  parameter int unsigned LONG_PRDS   = 100000,
  parameter int unsigned REPEAT_PRDS = 0,
  parameter int unsigned ACTIVE_LOW  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_i,
  input  logic [CHANNELS-1:0] btn_i,
  output logic [CHANNELS-1:0] btn_o,
  output logic [CHANNELS-1:0] press_o,
  output logic [CHANNELS-1:0] release_o,
  output logic [CHANNELS-1:0] long_o,
  output logic [CHANNELS-1:0] repeat_o
);

  localparam int unsigned FILT_W = $clog2(FILT_PRDS + 1);
  localparam int unsigned HOLD_W = (LONG_PRDS > 0) ? $clog2(LONG_PRDS + 1) : 1;
  localparam int unsigned REP_W  = (REPEAT_PRDS > 0) ? $clog2(REPEAT_PRDS + 1) : 1;
  localparam logic        PIN_IDLE = (ACTIVE_LOW != 0);

  generate
    if (FILT_PRDS < 1 || SYNC_STAGES < 2) begin : g_param_check
      $fatal(1, "btn_debounce_multi: FILT_PRDS must be >=1 and SYNC_STAGES >=2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q   [CHANNELS];
  logic [FILT_W-1:0]      filt_cnt [CHANNELS];
  logic [HOLD_W-1:0]      hold_cnt [CHANNELS];
  logic [REP_W-1:0]       rep_cnt  [CHANNELS];
  logic [CHANNELS-1:0]    s_c;
  logic [CHANNELS-1:0]    accept_c;

  // Synchronised, polarity-corrected level and "new level accepted this clk"
  always_comb begin
    s_c      = '0;
    accept_c = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      s_c[i]      = sync_q[i][SYNC_STAGES-1] ^ PIN_IDLE;
      accept_c[i] = (s_c[i] != btn_o[i]) && tick_i &&
                    (filt_cnt[i] == FILT_W'(FILT_PRDS - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_o     <= '0;
      press_o   <= '0;
      release_o <= '0;
      long_o    <= '0;
      repeat_o  <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        sync_q[i]   <= {SYNC_STAGES{PIN_IDLE}};
        filt_cnt[i] <= '0;
        hold_cnt[i] <= '0;
        rep_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        sync_q[i]    <= {sync_q[i][SYNC_STAGES-2:0], btn_i[i]};
        press_o[i]   <= accept_c[i] && !btn_o[i];
        release_o[i] <= accept_c[i] && btn_o[i];
        long_o[i]    <= 1'b0;
        repeat_o[i]  <= 1'b0;

        // Integrating filter: any agreement with the current level restarts the count
        if (s_c[i] == btn_o[i]) begin
          filt_cnt[i] <= '0;
        end else if (tick_i) begin
          if (accept_c[i]) begin
            btn_o[i]    <= s_c[i];
            filt_cnt[i] <= '0;
          end else begin
            filt_cnt[i] <= filt_cnt[i] + FILT_W'(1);
          end
        end

        // Hold/repeat timing; a level change in this clk (press or release) clears it
        if (LONG_PRDS == 0 || !btn_o[i] || accept_c[i]) begin
          hold_cnt[i] <= '0;
          rep_cnt[i]  <= '0;
        end else if (tick_i) begin
          if (hold_cnt[i] != HOLD_W'(LONG_PRDS)) begin
            hold_cnt[i] <= hold_cnt[i] + HOLD_W'(1);
            if (hold_cnt[i] == HOLD_W'(LONG_PRDS - 1)) begin
              long_o[i] <= 1'b1;
            end
          end else if (REPEAT_PRDS > 0) begin
            if (rep_cnt[i] == REP_W'(REPEAT_PRDS - 1)) begin
              repeat_o[i] <= 1'b1;
              rep_cnt[i]  <= '0;
            end else begin
              rep_cnt[i] <= rep_cnt[i] + REP_W'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi: active-high and active-low instances,
// expected edge numbers hand-derived for FILT_PRDS=4, SYNC_STAGES=2, LONG=10, REPEAT=3.
module tb_btn_debounce_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_i;
  logic [1:0] btn_i, btn_o, press_o, release_o, long_o, repeat_o;
  logic [1:0] al_btn_i, al_btn_o, al_press_o, al_release_o, al_long_o, al_repeat_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  btn_debounce_multi #(
    .CHANNELS(2), .SYNC_STAGES(2), .FILT_PRDS(4),
    .LONG_PRDS(10), .REPEAT_PRDS(3), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .tick_i(tick_i), .btn_i(btn_i),
    .btn_o(btn_o), .press_o(press_o), .release_o(release_o),
    .long_o(long_o), .repeat_o(repeat_o)
  );

  btn_debounce_multi #(
    .CHANNELS(2), .SYNC_STAGES(2), .FILT_PRDS(4),
    .LONG_PRDS(10), .REPEAT_PRDS(3), .ACTIVE_LOW(1)
  ) dut_al (
    .clk(clk), .rst(rst), .tick_i(tick_i), .btn_i(al_btn_i),
    .btn_o(al_btn_o), .press_o(al_press_o), .release_o(al_release_o),
    .long_o(al_long_o), .repeat_o(al_repeat_o)
  );

  // Advance one clk; outputs are then sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick_i = 1'b1; btn_i = 2'b00; al_btn_i = 2'b11;
    settle(3);
    n_vec++; if (btn_o !== 2'b00) begin n_err++; $display("FAIL reset_btn got %b exp 00", btn_o); end
    n_vec++; if ((press_o | release_o) !== 2'b00) begin n_err++; $display("FAIL reset_pr got %b/%b exp 00", press_o, release_o); end
    n_vec++; if ((long_o | repeat_o) !== 2'b00) begin n_err++; $display("FAIL reset_lr got %b/%b exp 00", long_o, repeat_o); end
    n_vec++; if (al_btn_o !== 2'b00) begin n_err++; $display("FAIL reset_al_btn got %b exp 00", al_btn_o); end
    rst = 1'b0;
    settle(8);
    n_vec++; if (al_btn_o !== 2'b00) begin n_err++; $display("FAIL idle_al_btn got %b exp 00", al_btn_o); end
  endtask

  task automatic test_clean_press();
    logic [1:0] eb, ep;
    btn_i = 2'b01;
    for (int e = 1; e <= 8; e++) begin
      step();
      eb = {1'b0, (e >= 6)};
      ep = {1'b0, (e == 6)};
      n_vec++; if (btn_o !== eb) begin n_err++; $display("FAIL clean_btn e%0d got %b exp %b", e, btn_o, eb); end
      n_vec++; if (press_o !== ep) begin n_err++; $display("FAIL clean_press e%0d got %b exp %b", e, press_o, ep); end
    end
    btn_i = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      step();
      ep = {1'b0, (e == 6)};
      n_vec++; if (release_o !== ep) begin n_err++; $display("FAIL clean_release e%0d got %b exp %b", e, release_o, ep); end
      n_vec++; if (btn_o[0] !== (e < 6)) begin n_err++; $display("FAIL clean_fall e%0d got %b exp %b", e, btn_o[0], (e < 6)); end
    end
  endtask

  task automatic test_bounce();
    for (int e = 1; e <= 24; e++) begin
      btn_i[0] = (e <= 3) || (e >= 5 && e <= 14);
      step();
      n_vec++; if (btn_o[0] !== (e >= 10 && e < 20)) begin n_err++; $display("FAIL bounce_btn e%0d got %b exp %b", e, btn_o[0], (e >= 10 && e < 20)); end
      n_vec++; if (press_o[0] !== (e == 10)) begin n_err++; $display("FAIL bounce_press e%0d got %b exp %b", e, press_o[0], (e == 10)); end
    end
    settle(4);
  endtask

  task automatic test_short_hold();
    btn_i[0] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 9) btn_i[0] = 1'b0;
      n_vec++; if (long_o[0] !== 1'b0) begin n_err++; $display("FAIL short_long e%0d got %b exp 0", e, long_o[0]); end
      n_vec++; if (release_o[0] !== (e == 15)) begin n_err++; $display("FAIL short_release e%0d got %b exp %b", e, release_o[0], (e == 15)); end
    end
  endtask

  task automatic test_long_repeat();
    logic er;
    btn_i[0] = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      if (e == 23) btn_i[0] = 1'b0;
      step();
      er = (e == 19) || (e == 22) || (e == 25);
      n_vec++; if (long_o[0] !== (e == 16)) begin n_err++; $display("FAIL long e%0d got %b exp %b", e, long_o[0], (e == 16)); end
      n_vec++; if (repeat_o[0] !== er) begin n_err++; $display("FAIL repeat e%0d got %b exp %b", e, repeat_o[0], er); end
      n_vec++; if (release_o[0] !== (e == 28)) begin n_err++; $display("FAIL lr_release e%0d got %b exp %b", e, release_o[0], (e == 28)); end
      n_vec++; if (repeat_o[1] !== 1'b0) begin n_err++; $display("FAIL lr_ch1 e%0d got %b exp 0", e, repeat_o[1]); end
    end
  endtask

  task automatic test_throttled_tick();
    btn_i[0] = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      tick_i = (e % 3 == 0);
      step();
      n_vec++; if (press_o[0] !== (e == 12)) begin n_err++; $display("FAIL thr_press e%0d got %b exp %b", e, press_o[0], (e == 12)); end
      n_vec++; if (btn_o[0] !== (e >= 12)) begin n_err++; $display("FAIL thr_btn e%0d got %b exp %b", e, btn_o[0], (e >= 12)); end
    end
    tick_i = 1'b1;
    btn_i[0] = 1'b0;
    settle(10);
    n_vec++; if (btn_o !== 2'b00) begin n_err++; $display("FAIL thr_idle got %b exp 00", btn_o); end
  endtask

  task automatic test_simultaneous();
    logic [1:0] ep;
    btn_i = 2'b11;
    for (int e = 1; e <= 8; e++) begin
      step();
      ep = (e == 6) ? 2'b11 : 2'b00;
      n_vec++; if (press_o !== ep) begin n_err++; $display("FAIL simul_press e%0d got %b exp %b", e, press_o, ep); end
    end
    btn_i = 2'b00;
    for (int e = 1; e <= 8; e++) begin
      step();
      ep = (e == 6) ? 2'b11 : 2'b00;
      n_vec++; if (release_o !== ep) begin n_err++; $display("FAIL simul_release e%0d got %b exp %b", e, release_o, ep); end
    end
  endtask

  task automatic test_active_low();
    logic [1:0] eb, ep;
    // Press ch0 and reset midway through the filter count
    al_btn_i = 2'b10;
    settle(4);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (al_btn_o !== 2'b00) begin n_err++; $display("FAIL al_midrst_btn got %b exp 00", al_btn_o); end
    step();
    step();
    n_vec++; if (al_press_o !== 2'b00) begin n_err++; $display("FAIL al_rst_press got %b exp 00", al_press_o); end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      eb = {1'b0, (e >= 6)};
      ep = {1'b0, (e == 6)};
      n_vec++; if (al_btn_o !== eb) begin n_err++; $display("FAIL al_btn e%0d got %b exp %b", e, al_btn_o, eb); end
      n_vec++; if (al_press_o !== ep) begin n_err++; $display("FAIL al_press e%0d got %b exp %b", e, al_press_o, ep); end
    end
    // Reset while pressed clears between edges, then a held pin re-debounces
    #3 rst = 1'b1;
    #1;
    n_vec++; if (al_btn_o !== 2'b00) begin n_err++; $display("FAIL al_async_btn got %b exp 00", al_btn_o); end
    step();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      ep = {1'b0, (e == 6)};
      n_vec++; if (al_press_o !== ep) begin n_err++; $display("FAIL al_repress e%0d got %b exp %b", e, al_press_o, ep); end
    end
    al_btn_i = 2'b11;
    for (int e = 1; e <= 8; e++) begin
      step();
      ep = {1'b0, (e == 6)};
      n_vec++; if (al_release_o !== ep) begin n_err++; $display("FAIL al_release e%0d got %b exp %b", e, al_release_o, ep); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_hold();
    test_long_repeat();
    test_throttled_tick();
    test_simultaneous();
    test_active_low();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
